vga_sprite_gen: RTL and testbench

VGA_SPRITE_GEN -- requirements
Module: vga_sprite_gen

---
 rtl/vga_sprite_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_sprite_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_gen.sv
// VGA timing generator with N fixed-colour box sprites and register-mapped positions.
// Define VGA_SHADOW_EN to latch sprite positions only at frame start (tear-free).
module vga_sprite_gen #(
    parameter int H_RES        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_RES        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int COUNTER_BITS = 10,
    parameter int N_SPRITES    = 3,
    parameter int BASE_ADDR    = 6000,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter logic [N_SPRITES*24-1:0] SPRITE_RGB =
        {24'hFF0000, 24'h00FF00, 24'h0000FF},
    parameter logic [23:0] BG_RGB = 24'h000000
) (
    input  logic        clk_50MHz,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        clk_25MHz,
    output logic        h_sync,
    output logic        v_sync,
    output logic        sync_n,
    output logic        blank_n,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        frame_start
);

    localparam int CB    = COUNTER_BITS;
    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CB-1:0] H_LAST   = CB'(H_TOT - 1);
    localparam logic [CB-1:0] V_LAST   = CB'(V_TOT - 1);
    localparam logic [CB-1:0] H_VIS    = CB'(H_RES);
    localparam logic [CB-1:0] V_VIS    = CB'(V_RES);
    localparam logic [CB-1:0] HS_FIRST = CB'(H_RES + H_FP);
    localparam logic [CB-1:0] HS_LAST  = CB'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CB-1:0] VS_FIRST = CB'(V_RES + V_FP);
    localparam logic [CB-1:0] VS_LAST  = CB'(V_RES + V_FP + V_SYNC - 1);

    logic          pix_en;
    logic          h_wrap;
    logic          v_wrap;
    logic [CB-1:0] h_cnt;
    logic [CB-1:0] v_cnt;

    logic [15:0] wr_x   [N_SPRITES];
    logic [15:0] wr_y   [N_SPRITES];
    logic [15:0] disp_x [N_SPRITES];
    logic [15:0] disp_y [N_SPRITES];

    logic [16:0] h_ext;
    logic [16:0] v_ext;
    logic [23:0] pix_rgb;
    logic        visible;
    logic        hs_act;
    logic        vs_act;

    assign sync_n = 1'b0;
    assign pix_en = clk_25MHz;
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign frame_start = pix_en & h_wrap & v_wrap;

    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            clk_25MHz <= 1'b0;
        end else begin
            clk_25MHz <= ~clk_25MHz;
        end
    end

    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // X at BASE+8i, Y at BASE+8i+4; anything else falls through untouched
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                wr_x[i] <= 16'hFFFF;
                wr_y[i] <= 16'hFFFF;
            end
        end else if (wr_en) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (wr_addr == 16'(BASE_ADDR + 8 * i))
                    wr_x[i] <= wr_data;
                if (wr_addr == 16'(BASE_ADDR + 8 * i + 4))
                    wr_y[i] <= wr_data;
            end
        end
    end

`ifdef VGA_SHADOW_EN
    // copy sees the pre-write value, so a boundary write lands next frame
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                disp_x[i] <= 16'hFFFF;
                disp_y[i] <= 16'hFFFF;
            end
        end else if (frame_start) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                disp_x[i] <= wr_x[i];
                disp_y[i] <= wr_y[i];
            end
        end
    end
`else
    assign disp_x = wr_x;
    assign disp_y = wr_y;
`endif

    assign h_ext = 17'(h_cnt);
    assign v_ext = 17'(v_cnt);

    // walk high to low so the lowest-index covering sprite wins
    always_comb begin
        pix_rgb = BG_RGB;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if ({1'b0, disp_x[i]} <= h_ext &&
                h_ext < {1'b0, disp_x[i]} + 17'(SPRITE_W) &&
                {1'b0, disp_y[i]} <= v_ext &&
                v_ext < {1'b0, disp_y[i]} + 17'(SPRITE_H))
                pix_rgb = SPRITE_RGB[24*i +: 24];
        end
    end

    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_act  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_act  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            h_sync    <= 1'b1;
            v_sync    <= 1'b1;
            blank_n   <= 1'b0;
            red_out   <= 8'h00;
            green_out <= 8'h00;
            blue_out  <= 8'h00;
        end else if (pix_en) begin
            h_sync  <= ~hs_act;
            v_sync  <= ~vs_act;
            blank_n <= visible;
            {red_out, green_out, blue_out} <= visible ? pix_rgb : 24'h000000;
        end
    end

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Directed bench for vga_sprite_gen on a shrunk 48x32 raster.
// Pixel expectations are hand-computed from the geometry below.
module tb_vga_sprite_gen;

    localparam int HT   = 48;
    localparam int FRM  = 2 * 48 * 32;
    localparam int BASE = 6000;

    localparam logic [23:0] S0 = 24'hFF0000;
    localparam logic [23:0] S1 = 24'h00FF00;
    localparam logic [23:0] S2 = 24'h0000FF;
    localparam logic [23:0] BG = 24'h123456;

    logic        clk_50MHz = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clk_25MHz;
    logic        h_sync;
    logic        v_sync;
    logic        sync_n;
    logic        blank_n;
    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;
    logic        frame_start;

    vga_sprite_gen #(
        .H_RES(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_RES(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .COUNTER_BITS(10), .N_SPRITES(3), .BASE_ADDR(BASE),
        .SPRITE_W(4), .SPRITE_H(4),
        .SPRITE_RGB({S2, S1, S0}), .BG_RGB(BG)
    ) dut (
        .clk_50MHz(clk_50MHz), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clk_25MHz(clk_25MHz), .h_sync(h_sync), .v_sync(v_sync),
        .sync_n(sync_n), .blank_n(blank_n),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .frame_start(frame_start)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    typedef struct {
        int          h;
        int          v;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   errs = 0;
    int   ed = 0;

    function automatic vec_t px(int h, int v, logic b, logic hs,
                                logic vs, logic [23:0] rgb);
        vec_t t;
        t.h = h;
        t.v = v;
        t.exp = {b, hs, vs, rgb};
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
        ed++;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (!frame_start && n < 3 * FRM) begin
            step();
            n++;
        end
        if (!frame_start) begin
            nvec++;
            errs++;
            $display("FAIL frame_timeout: got none expected pulse");
        end
        step();
        n++;
        ed = 0;
    endtask

    task automatic at_pix(int h, int v);
        int target;
        target = 2 * (v * HT + h) + 2;
        while (ed < target) step();
    endtask

    task automatic wr(int addr, int data);
        wr_en = 1'b1;
        wr_addr = 16'(addr);
        wr_data = 16'(data);
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [26:0] outs();
        return {blank_n, h_sync, v_sync, red_out, green_out, blue_out};
    endfunction

    task automatic chk_reset_state(string tag);
        chk({tag, "_hs"}, 32'(h_sync), 32'd1);
        chk({tag, "_vs"}, 32'(v_sync), 32'd1);
        chk({tag, "_blank"}, 32'(blank_n), 32'd0);
        chk({tag, "_rgb"}, 32'({red_out, green_out, blue_out}), 32'd0);
        chk({tag, "_clk25"}, 32'(clk_25MHz), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int n;
        int hs_low, vs_low, bl, f1, f2;
        logic prev_hs;

        tbl.push_back(px( 0,  0, 1, 1, 1, BG));
        tbl.push_back(px( 9,  5, 1, 1, 1, BG));
        tbl.push_back(px(10,  5, 1, 1, 1, S0));
        tbl.push_back(px(13,  5, 1, 1, 1, S0));
        tbl.push_back(px(14,  5, 1, 1, 1, BG));
        tbl.push_back(px(36,  5, 0, 0, 1, 24'h0));
        tbl.push_back(px(43,  5, 0, 0, 1, 24'h0));
        tbl.push_back(px(44,  5, 0, 1, 1, 24'h0));
        tbl.push_back(px(12,  7, 1, 1, 1, S0));
        tbl.push_back(px(15,  7, 1, 1, 1, S1));
        tbl.push_back(px(12,  9, 1, 1, 1, S1));
        tbl.push_back(px(16, 10, 1, 1, 1, BG));
        tbl.push_back(px(10, 11, 1, 1, 1, BG));
        tbl.push_back(px(30, 22, 1, 1, 1, S2));
        tbl.push_back(px(31, 23, 1, 1, 1, S2));
        tbl.push_back(px(32, 23, 0, 1, 1, 24'h0));
        tbl.push_back(px( 0, 24, 0, 1, 1, 24'h0));
        tbl.push_back(px( 0, 26, 0, 1, 0, 24'h0));
        tbl.push_back(px( 0, 27, 0, 1, 0, 24'h0));
        tbl.push_back(px( 0, 28, 0, 1, 1, 24'h0));
        tbl.push_back(px(47, 31, 0, 1, 1, 24'h0));

        // reset held, then first frame_start latency
        repeat (5) step();
        chk_reset_state("reset");
        chk("sync_n", 32'(sync_n), 32'd0);
        clear = 1'b1;
        wait_frame(n);
        chk("fs_latency", 32'(n), 32'(FRM));
        chk("fs_width", 32'(frame_start), 32'd0);

        // sprite setup plus two writes that must decode to nothing
        wr(BASE + 0, 10);
        wr(BASE + 4, 5);
        wr(BASE + 8, 12);
        wr(BASE + 12, 7);
        wr(BASE + 16, 30);
        wr(BASE + 20, 22);
        wr(BASE + 2, 0);
        wr(BASE + 24, 0);
        wait_frame(n);
        foreach (tbl[i]) begin
            at_pix(tbl[i].h, tbl[i].v);
            chk($sformatf("pix_%0d_%0d", tbl[i].h, tbl[i].v),
                32'(outs()), 32'(tbl[i].exp));
        end

        // sync/blank timing over one frame
        wait_frame(n);
        hs_low = 0; vs_low = 0; bl = 0; f1 = -1; f2 = -1;
        prev_hs = h_sync;
        for (int i = 0; i < FRM - 2; i++) begin
            step();
            if (ed < 98 && !h_sync) hs_low++;
            if (!v_sync) vs_low++;
            if (blank_n) bl++;
            if (prev_hs && !h_sync) begin
                if (f1 < 0) f1 = ed;
                else if (f2 < 0) f2 = ed;
            end
            prev_hs = h_sync;
        end
        chk("hsync_low", 32'(hs_low), 32'd16);
        chk("line_period", 32'(f2 - f1), 32'd96);
        chk("vsync_low", 32'(vs_low), 32'd192);
        chk("visible_cycles", 32'(bl), 32'd1536);

        // mid-frame move of sprite 1
        wait_frame(n);
        at_pix(0, 2);
        wr(BASE + 8, 20);
        at_pix(14, 9);
`ifdef VGA_SHADOW_EN
        chk("move_old_pos", 32'({red_out, green_out, blue_out}), 32'(S1));
`else
        chk("move_old_pos", 32'({red_out, green_out, blue_out}), 32'(BG));
`endif
        at_pix(20, 9);
`ifdef VGA_SHADOW_EN
        chk("move_new_pos", 32'({red_out, green_out, blue_out}), 32'(BG));
`else
        chk("move_new_pos", 32'({red_out, green_out, blue_out}), 32'(S1));
`endif
        wait_frame(n);
        at_pix(14, 9);
        chk("next_old_pos", 32'({red_out, green_out, blue_out}), 32'(BG));
        at_pix(20, 9);
        chk("next_new_pos", 32'({red_out, green_out, blue_out}), 32'(S1));

        // clear mid-frame: immediate reset, then a clean restart
        at_pix(5, 3);
        clear = 1'b0;
        #1;
        chk_reset_state("midclr");
        step();
        step();
        clear = 1'b1;
        wait_frame(n);
        chk("restart_latency", 32'(n), 32'(FRM));
        at_pix(0, 0);
        chk("restart_pix0", 32'(outs()), 32'({3'b111, BG}));
        at_pix(10, 5);
        chk("restart_sprites_off", 32'(outs()), 32'({3'b111, BG}));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
